// File: rtl/pipe_addsub.sv
// pipe_addsub: WIDTH-bit adder/subtractor, carry chain cut into STAGES registered chunks,
// valid/ready on both sides. Build macro PIPE_ADDSUB_SAT_EN clamps overflowed sums.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic              advance;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  sum_raw;
    logic [WIDTH-1:0]  sum_d;
    logic              cin_eff;
    logic              c_last;
    logic              msb_cin;
    logic              ovf_d;
`ifdef PIPE_ADDSUB_SAT_EN
    logic              a_msb;
`endif

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];

    // Subtract as a + ~b + ~c_in.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = c_in ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int WA = WIDTH - k*CHUNK;

        logic [WA-1:0]          src_a;
        logic [WA-1:0]          src_b;
        logic [CHUNK-1:0]       s;
        logic                   ci;
        logic                   co;
        logic [(k+1)*CHUNK-1:0] res_d;

        if (k == 0) begin : g_head
            assign src_a = a;
            assign src_b = b_eff;
            assign ci    = cin_eff;
            assign res_d = s;
        end else begin : g_tail
            assign src_a = g_stg[k-1].g_mid.opa_q;
            assign src_b = g_stg[k-1].g_mid.opb_q;
            assign ci    = g_stg[k-1].g_mid.cy_q;
            assign res_d = {s, g_stg[k-1].g_mid.res_q};
        end

        assign {co, s} = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, ci};

        if (k < STAGES-1) begin : g_mid
            // Remaining operand slices ride along shifted down so the next chunk sits at bit 0.
            logic [WA-CHUNK-1:0]    opa_q;
            logic [WA-CHUNK-1:0]    opb_q;
            logic [(k+1)*CHUNK-1:0] res_q;
            logic                   cy_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    res_q <= '0;
                    cy_q  <= 1'b0;
                end else if (advance) begin
                    opa_q <= src_a[WA-1:CHUNK];
                    opb_q <= src_b[WA-1:CHUNK];
                    res_q <= res_d;
                    cy_q  <= co;
                end
            end
        end else begin : g_last
            assign sum_raw = res_d;
            assign c_last  = co;
            // Carry into the MSB recovered from the MSB sum bit.
            assign msb_cin = src_a[CHUNK-1] ^ src_b[CHUNK-1] ^ s[CHUNK-1];
`ifdef PIPE_ADDSUB_SAT_EN
            assign a_msb   = src_a[CHUNK-1];
`endif
        end
    end

    assign ovf_d = msb_cin ^ c_last;

`ifdef PIPE_ADDSUB_SAT_EN
    // On overflow the true result has the sign of a, in both add and sub.
    always_comb begin
        sum_d = sum_raw;
        if (ovf_d)
            sum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign sum_d = sum_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_pipe[STAGES-1:0];
            sum   <= sum_d;
            c_out <= c_last;
            ovf   <= ovf_d;
        end
    end

endmodule
